cond_unit: RTL and testbench
============================

Name: cond_unit

Overview:
- Condition-logic stage directly downstream of the ALU.
- Holds the architectural NZCV flag register and loads it from ALUFlags under FlagW control.
- Evaluates the 4-bit ARM condition field against the stored flags and gates the decoder's PCS/RegW/MemW strobes into PCSrc/RegWrite/MemWrite.
- Keeps saturating executed/skipped instruction counters for debug.

Parameters:
- CNT_W, 16, width of the ExecCount and SkipCount counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- InstrValid  input  1  an instruction is present this cycle.
- Stall  input  1  hold; blocks flag and counter updates, forces gated strobes to 0.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
- FlagW  input  2  [1] = update N,Z; [0] = update C,V.
- PCS  input  1  decoder: instruction writes PC.
- RegW  input  1  decoder: instruction writes the register file.
- MemW  input  1  decoder: instruction writes memory.
- NoWrite  input  1  decoder: compare-type instruction; suppress RegWrite.
- CntClr  input  1  synchronous clear of both counters.
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register write.
- MemWrite  output  1  gated memory write.
- CondEx  output  1  condition passed for the current instruction.
- Flags  output  4  stored {N,Z,C,V}.
- ExecCount  output  CNT_W  instructions executed.
- SkipCount  output  CNT_W  instructions skipped on a failed condition.

Behaviour:
- Reset (async, active-high): Flags=0000, ExecCount=0, SkipCount=0. Combinational outputs follow from the cleared state; e.g. Cond=0000 (EQ) gives CondEx=0.
- Reset mid-operation clears state immediately, with no clock needed. The first edge after deassertion updates normally.
- Qualifier: Act = InstrValid & ~Stall.
- CondEx (combinational, from stored Flags, never from ALUFlags):
  - EQ 0000: Z. NE 0001: ~Z.
  - CS 0010: C. CC 0011: ~C.
  - MI 0100: N. PL 0101: ~N.
  - VS 0110: V. VC 0111: ~V.
  - HI 1000: C&~Z. LS 1001: ~C|Z.
  - GE 1010: N==V. LT 1011: N!=V.
  - GT 1100: ~Z&(N==V). LE 1101: Z|(N!=V).
  - AL 1110: 1.
  - 1111: 0 (unsupported encoding, treated as never).
- Gated strobes (combinational, zero latency, same cycle as inputs):
  - PCSrc = Act & CondEx & PCS.
  - RegWrite = Act & CondEx & RegW & ~NoWrite.
  - MemWrite = Act & CondEx & MemW.
- Flag register update at posedge when Act & CondEx:
  - FlagW[1] loads N,Z from ALUFlags[3:2].
  - FlagW[0] loads C,V from ALUFlags[1:0].
  - The two halves are independent.
- Flags written by instruction i are first visible to the condition check of instruction i+1. There is no bypass from ALUFlags.
- Failed condition: no flag update, even with FlagW=11.
- Counters at posedge:
  - CntClr has priority and zeroes both counters.
  - Else if Act&CondEx, ExecCount+1.
  - Else if Act&~CondEx, SkipCount+1.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- CntClr coinciding with Act: clear wins; that instruction is not counted. A simultaneous flag update still occurs.
- Stall=1 or InstrValid=0: all state holds and all gated strobes are 0. CondEx still reflects Cond vs Flags (informational only).

Decomposition:
- Shared package:
  - Condition code constants COND_EQ..COND_NV.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - FlagW bit indices FLAGW_NZ=1, FLAGW_CV=0.
  - These same indices describe the ALU's ALUFlags packing.
- One sub-module, cond_check: purely combinational (Cond, Flags) -> CondEx. It is reusable by a later pipelined hazard/branch unit.
- Flag register and counters stay in cond_unit.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with Flags=1111 and counters non-zero -> Flags=0000 and both counters 0 before the next edge; Cond=1110 with RegW=1, InstrValid=1 -> RegWrite=1.
- Flag split: Cond=AL, FlagW=10, ALUFlags=1111 -> Flags=1100 after the edge. Then FlagW=01, ALUFlags=0011 -> Flags=1111.
- Conditions: sweep all 16 Cond values against all 16 Flags values -> CondEx matches the table above. Spot checks:
  - Flags=0100 (Z) with HI -> 0, with LS -> 1.
  - Flags=1001 (N,V) with GE -> 1, with GT -> 1.
  - Cond=1111 -> 0 for every Flags value.
- Failed-condition suppression: Flags=0000, Cond=EQ, FlagW=11, ALUFlags=0100, RegW=MemW=PCS=1 -> all strobes 0, Flags stays 0000, SkipCount+1.
- NoWrite/Stall: Cond=AL, RegW=1, NoWrite=1 -> RegWrite=0. With Stall=1, FlagW=11 -> no flag change, counters unchanged, strobes 0.
- Counters: CNT_W=4, 20 executed instructions -> ExecCount=15 (saturated). Then CntClr with Act&CondEx on the same cycle -> ExecCount=0 after the edge.

Source files
------------

// File: rtl/cond_unit_pkg.sv
// cond_unit_pkg: condition codes and NZCV / FlagW bit positions shared with the ALU
package cond_unit_pkg;
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  localparam int FLAGW_NZ = 1;
  localparam int FLAGW_CV = 0;
endpackage

// File: rtl/cond_unit_check.sv
// cond_check: combinational ARM condition evaluation against stored NZCV flags
module cond_check
  import cond_unit_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);
  logic w_n, w_z, w_c, w_v, w_ge;
  assign w_n  = i_flags[FLAG_N];
  assign w_z  = i_flags[FLAG_Z];
  assign w_c  = i_flags[FLAG_C];
  assign w_v  = i_flags[FLAG_V];
  assign w_ge = (w_n == w_v);
  always_comb begin
    case (i_cond)
      COND_EQ: o_cond_ex = w_z;
      COND_NE: o_cond_ex = ~w_z;
      COND_CS: o_cond_ex = w_c;
      COND_CC: o_cond_ex = ~w_c;
      COND_MI: o_cond_ex = w_n;
      COND_PL: o_cond_ex = ~w_n;
      COND_VS: o_cond_ex = w_v;
      COND_VC: o_cond_ex = ~w_v;
      COND_HI: o_cond_ex = w_c & ~w_z;
      COND_LS: o_cond_ex = ~w_c | w_z;
      COND_GE: o_cond_ex = w_ge;
      COND_LT: o_cond_ex = ~w_ge;
      COND_GT: o_cond_ex = ~w_z & w_ge;
      COND_LE: o_cond_ex = w_z | ~w_ge;
      COND_AL: o_cond_ex = 1'b1;
      default: o_cond_ex = 1'b0;
    endcase
  end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: NZCV flag register, condition gating of write strobes, saturating exec/skip counters
module cond_unit
  import cond_unit_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic             Stall,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             CntClr,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
);
  logic [3:0]       r_flags;
  logic [CNT_W-1:0] r_exec, r_skip;
  logic             w_cond_ex, w_act, w_exec;
  cond_check u_check (
    .i_cond   (Cond),
    .i_flags  (r_flags),
    .o_cond_ex(w_cond_ex)
  );
  assign w_act     = InstrValid & ~Stall;
  assign w_exec    = w_act & w_cond_ex;
  assign CondEx    = w_cond_ex;
  assign PCSrc     = w_exec & PCS;
  assign RegWrite  = w_exec & RegW & ~NoWrite;
  assign MemWrite  = w_exec & MemW;
  assign Flags     = r_flags;
  assign ExecCount = r_exec;
  assign SkipCount = r_skip;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
      r_exec  <= '0;
      r_skip  <= '0;
    end else begin
      if (w_exec && FlagW[FLAGW_NZ]) r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (w_exec && FlagW[FLAGW_CV]) r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      // clear outranks counting; saturated counters simply hold
      if (CntClr) begin
        r_exec <= '0;
        r_skip <= '0;
      end else if (w_exec) begin
        if (r_exec != '1) r_exec <= r_exec + 1'b1;
      end else if (w_act) begin
        if (r_skip != '1) r_skip <= r_skip + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit: scoreboard-driven bench for cond_unit (CNT_W=4 to reach saturation quickly)
`timescale 1ns/1ps
module tb_cond_unit;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic reset, InstrValid, Stall, PCS, RegW, MemW, NoWrite, CntClr;
  logic [3:0] Cond, ALUFlags, Flags;
  logic [1:0] FlagW;
  logic PCSrc, RegWrite, MemWrite, CondEx;
  logic [CW-1:0] ExecCount, SkipCount;
  int errors = 0;
  int checks = 0;
  logic [15:0] q[$];
  logic [15:0] e;

  cond_unit #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .InstrValid(InstrValid), .Stall(Stall), .Cond(Cond),
    .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
    .NoWrite(NoWrite), .CntClr(CntClr), .PCSrc(PCSrc), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags), .ExecCount(ExecCount),
    .SkipCount(SkipCount)
  );

  always #5 clk = ~clk;

  // Reference table built from ARM's base-condition/invert-bit structure
  function automatic logic model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    {n, z, cy, v} = f;
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return (c[3:1] == 3'd7) ? ~c[0] : (b ^ c[0]);
  endfunction

  task automatic drive(input logic v, input logic s, input logic [3:0] c, input logic [3:0] a,
                       input logic [1:0] fw, input logic p, input logic r, input logic m,
                       input logic nw, input logic cc);
    @(negedge clk);
    InstrValid = v; Stall = s; Cond = c; ALUFlags = a; FlagW = fw;
    PCS = p; RegW = r; MemW = m; NoWrite = nw; CntClr = cc;
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    q.push_back({4'h0, 4'h0, 4'h0, 4'h0});
    e = q.pop_front();
    checks++;
    if ({Flags, ExecCount, SkipCount, 3'b000, CondEx} !== e) begin
      errors++;
      $display("FAIL reset_init: got %h want %h", {Flags, ExecCount, SkipCount, 3'b000, CondEx}, e);
    end
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 4'hE, 4'hF, 2'b11, 0, 0, 0, 0, 0);
    edge_wait();
    drive(1, 0, 4'hF, 4'h0, 2'b11, 0, 0, 0, 0, 0);
    q.push_back({4'hF, 4'h1, 4'h1, 4'h0});
    edge_wait();
    e = q.pop_front();
    checks++;
    if ({Flags, ExecCount, SkipCount, 4'h0} !== e) begin
      errors++;
      $display("FAIL reset_prestate: got %h want %h", {Flags, ExecCount, SkipCount, 4'h0}, e);
    end
    drive(0, 0, 4'h0, 4'h0, 2'b00, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    q.push_back(16'h0000);
    #1;
    e = q.pop_front();
    checks++;
    if ({Flags, ExecCount, SkipCount, 4'h0} !== e) begin
      errors++;
      $display("FAIL reset_async: got %h want %h", {Flags, ExecCount, SkipCount, 4'h0}, e);
    end
    reset = 1'b0;
    InstrValid = 1'b1; Cond = 4'hE; RegW = 1'b1;
    q.push_back(16'h0001);
    #1;
    e = q.pop_front();
    checks++;
    if ({15'b0, RegWrite} !== e) begin
      errors++;
      $display("FAIL reset_regwrite_al: got %b want %b", RegWrite, e[0]);
    end
    q.push_back({4'h0, 4'h1, 4'h0, 4'h0});
    edge_wait();
    e = q.pop_front();
    checks++;
    if ({Flags, ExecCount, SkipCount, 4'h0} !== e) begin
      errors++;
      $display("FAIL reset_first_edge: got %h want %h", {Flags, ExecCount, SkipCount, 4'h0}, e);
    end
  endtask

  task automatic test_flag_split();
    drive(1, 0, 4'hE, 4'hF, 2'b10, 0, 0, 0, 0, 0);
    q.push_back({12'h0, 4'hC});
    edge_wait();
    e = q.pop_front();
    checks++;
    if ({12'h0, Flags} !== e) begin
      errors++;
      $display("FAIL flag_split_nz: got %b want %b", Flags, e[3:0]);
    end
    drive(1, 0, 4'hE, 4'h3, 2'b01, 0, 0, 0, 0, 0);
    q.push_back({12'h0, 4'hF});
    edge_wait();
    e = q.pop_front();
    checks++;
    if ({12'h0, Flags} !== e) begin
      errors++;
      $display("FAIL flag_split_cv: got %b want %b", Flags, e[3:0]);
    end
  endtask

  task automatic test_conditions();
    for (int f = 0; f < 16; f++) begin
      drive(1, 0, 4'hE, 4'(f), 2'b11, 0, 0, 0, 0, 0);
      q.push_back({12'h0, 4'(f)});
      edge_wait();
      e = q.pop_front();
      checks++;
      if ({12'h0, Flags} !== e) begin
        errors++;
        $display("FAIL cond_load flags=%0d: got %b want %b", f, Flags, e[3:0]);
      end
      for (int c = 0; c < 16; c++) begin
        drive(0, 0, 4'(c), 4'h0, 2'b11, 1, 1, 1, 0, 0);
        q.push_back({12'h0, 1'b0, 1'b0, 1'b0, model(4'(c), 4'(f))});
        #1;
        e = q.pop_front();
        checks++;
        if ({12'h0, PCSrc, RegWrite, MemWrite, CondEx} !== e) begin
          errors++;
          $display("FAIL cond_eval cond=%h flags=%h: got strobes/condex %b want %b",
                   c, f, {PCSrc, RegWrite, MemWrite, CondEx}, e[3:0]);
        end
      end
    end
  endtask

  task automatic test_fail_suppress();
    drive(1, 0, 4'hE, 4'h0, 2'b11, 0, 0, 0, 0, 1);
    edge_wait();
    drive(1, 0, 4'h0, 4'h4, 2'b11, 1, 1, 1, 0, 0);
    q.push_back(16'h0000);
    #1;
    e = q.pop_front();
    checks++;
    if ({12'h0, PCSrc, RegWrite, MemWrite, CondEx} !== e) begin
      errors++;
      $display("FAIL fail_strobes: got %b want %b", {PCSrc, RegWrite, MemWrite, CondEx}, e[3:0]);
    end
    q.push_back({4'h0, 4'h0, 4'h1, 4'h0});
    edge_wait();
    e = q.pop_front();
    checks++;
    if ({Flags, ExecCount, SkipCount, 4'h0} !== e) begin
      errors++;
      $display("FAIL fail_state: got %h want %h", {Flags, ExecCount, SkipCount, 4'h0}, e);
    end
  endtask

  task automatic test_nowrite_stall();
    drive(1, 0, 4'hE, 4'h0, 2'b00, 1, 1, 1, 1, 0);
    q.push_back(16'b1011);
    #1;
    e = q.pop_front();
    checks++;
    if ({12'h0, PCSrc, RegWrite, MemWrite, CondEx} !== e) begin
      errors++;
      $display("FAIL nowrite_strobes: got %b want %b", {PCSrc, RegWrite, MemWrite, CondEx}, e[3:0]);
    end
    edge_wait();
    drive(1, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 0);
    q.push_back(16'b0001);
    #1;
    e = q.pop_front();
    checks++;
    if ({12'h0, PCSrc, RegWrite, MemWrite, CondEx} !== e) begin
      errors++;
      $display("FAIL stall_strobes: got %b want %b", {PCSrc, RegWrite, MemWrite, CondEx}, e[3:0]);
    end
    q.push_back({4'h0, 4'h1, 4'h1, 4'h0});
    edge_wait();
    e = q.pop_front();
    checks++;
    if ({Flags, ExecCount, SkipCount, 4'h0} !== e) begin
      errors++;
      $display("FAIL stall_state: got %h want %h", {Flags, ExecCount, SkipCount, 4'h0}, e);
    end
  endtask

  task automatic test_counters();
    drive(0, 0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 1);
    edge_wait();
    for (int i = 1; i <= 20; i++) begin
      drive(1, 0, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 0);
      q.push_back({8'h0, 4'((i > 15) ? 15 : i), 4'h0});
      edge_wait();
      e = q.pop_front();
      checks++;
      if ({8'h0, ExecCount, SkipCount} !== e) begin
        errors++;
        $display("FAIL exec_count i=%0d: got %h want %h", i, {ExecCount, SkipCount}, e[7:0]);
      end
    end
    for (int i = 1; i <= 18; i++) begin
      drive(1, 0, 4'hF, 4'h0, 2'b11, 0, 0, 0, 0, 0);
      q.push_back({8'h0, 4'hF, 4'((i > 15) ? 15 : i)});
      edge_wait();
      e = q.pop_front();
      checks++;
      if ({8'h0, ExecCount, SkipCount} !== e) begin
        errors++;
        $display("FAIL skip_count i=%0d: got %h want %h", i, {ExecCount, SkipCount}, e[7:0]);
      end
    end
    drive(1, 0, 4'hE, 4'hA, 2'b11, 0, 0, 0, 0, 1);
    q.push_back({4'hA, 4'h0, 4'h0, 4'h0});
    edge_wait();
    e = q.pop_front();
    checks++;
    if ({Flags, ExecCount, SkipCount, 4'h0} !== e) begin
      errors++;
      $display("FAIL clr_with_exec: got %h want %h", {Flags, ExecCount, SkipCount, 4'h0}, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    InstrValid = 0; Stall = 0; Cond = 0; ALUFlags = 0; FlagW = 0;
    PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; CntClr = 0;
    test_reset();
    test_flag_split();
    test_conditions();
    test_fail_suppress();
    test_nowrite_stall();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
